// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: operands are accepted over valid/ready, summed LSB-first
// through one shared full-adder cell over WIDTH cycles, and the result held until taken.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_sh_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, carry_nxt;
    logic             s1, c1, s, c2;
    logic             last;

    // Shared full-adder cell: two half adders plus an OR for the carry.
    always_comb begin
        s1         = a_sh[0] ^ b_sh[0];
        c1         = a_sh[0] & b_sh[0];
        s          = s1 ^ carry;
        c2         = s1 & carry;
        carry_nxt  = c1 | c2;
        sum_sh_nxt = sum_sh >> 1;
        sum_sh_nxt[WIDTH-1] = s;
        last       = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // sum/cout are separate holding registers so they only change when a result completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    carry <= cin;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_sh_nxt;
                    carry  <= carry_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        sum  <= sum_sh_nxt;
                        cout <= carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 instance driven by directed and random
// traffic against an arithmetic reference model, plus an exhaustive WIDTH=1 instance.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic         in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b1, cout, busy;
    logic [W-1:0] a = '0, b = '0, sum;

    serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    // WIDTH=1 instance
    logic in_valid1 = 1'b0, in_ready1, cin1 = 1'b0, out_valid1, cout1, busy1;
    logic [0:0] a1 = '0, b1 = '0, sum1;

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(1'b1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level timing (accept, WIDTH cycles of work, hold until taken)
    logic [W:0] exp_q[$];
    int  m_phase = 0;   // 0 idle, 1 working, 2 result offered
    int  m_left  = 0;
    bit  rand_ready = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            exp_q.delete();
        end else begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            case (m_phase)
                0: if (in_valid) begin
                    exp_q.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(cin));
                    m_phase = 1;
                    m_left  = W;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Output monitor: pops an expected result when a new result appears, then checks it holds.
    logic [W:0] held = '0;
    bit         seen = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
            held = '0;
        end else if (out_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                held = exp_q.pop_front();
                chk("result", {cout, sum}, held);
            end
        end else if (out_valid) begin
            chk("result_stable", {cout, sum}, held);
        end else begin
            seen = 1'b0;
            if (in_ready) chk("idle_retain", {cout, sum}, held);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n;
        @(posedge clk); #1;
        a = x; b = y; cin = c; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_phase != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (exp_q.size() == 0 && m_phase == 0), 1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk); #1 rst_n = 1'b1;

        // WIDTH=1: all operand combinations, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            @(posedge clk); #1;
            a1 = v[0]; b1 = v[1]; cin1 = v[2]; in_valid1 = 1'b1;
            @(negedge clk);
            chk("w1_in_ready", in_ready1, 1);
            @(posedge clk); #1 in_valid1 = 1'b0;
            @(negedge clk);
            chk("w1_busy_run", busy1, 1);
            chk("w1_not_valid_yet", out_valid1, 0);
            @(negedge clk);
            chk("w1_valid", out_valid1, 1);
            chk("w1_result", {cout1, sum1}, 2'(v[0]) + 2'(v[1]) + 2'(v[2]));
        end

        // Directed WIDTH=8 cases
        out_ready = 1'b1;
        issue(8'h5A, 8'h3C, 1'b0);
        issue(8'hFF, 8'h01, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1);
        issue(8'h00, 8'h00, 1'b1);
        drain();

        // Backpressure: hold the result for 5 cycles
        out_ready = 1'b0;
        issue(8'h5A, 8'h3C, 1'b0);
        repeat (W + 5) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Requests during RUN/DONE are ignored until the block is idle again
        issue(8'h5A, 8'h3C, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = k[0];
        end
        issue(8'h11, 8'h22, 1'b0);
        drain();

        // Asynchronous reset mid-operation
        issue(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        issue(8'h01, 8'h01, 1'b0);
        drain();

        // Random operations with random consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rand_ready = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It then feeds them LSB-first through one full-adder cell, built as two half-adder stages plus an OR, for WIDTH cycles, and presents the sum and carry-out over a second valid/ready handshake. It lets small-area datapaths trade latency for a single shared adder cell.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, cin valid this cycle
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into bit 0
out_valid  output  1  sum/cout valid (high only in DONE)
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, low WIDTH bits
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async assert, any state, including mid-RUN/DONE):
  - FSM to IDLE; operand shift registers, sum register, carry flop, bit counter all 0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a and b into shift regs, carry<=cin, count<=0, go to RUN.
  - in_valid=0: stay in IDLE.
- RUN (exactly WIDTH cycles):
  - in_ready=0; in_valid ignored.
  - Each edge: s1=a0^b0, c1=a0&b0; s=s1^carry, c2=s1&carry; carry<=c1|c2.
  - Each edge: shift the operand regs right by 1; shift s into the sum reg MSB (sum reg shifts right); count<=count+1.
  - On the edge where count==WIDTH-1, go to DONE. The sum reg then holds the full result, bit i = sum bit i, and carry holds cout.
- DONE:
  - out_valid=1; sum/cout stable and unchanged while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go to IDLE.
  - sum/cout keep their last value in IDLE until the next result overwrites them.
- Latency:
  - Accept edge E0. Result valid after edge E0+WIDTH (out_valid high in the cycle following it).
  - Minimum issue interval is WIDTH+2 cycles with out_ready held high.
  - No overlap: a new accept occurs only in IDLE.
- Arithmetic: unsigned, modulo 2^WIDTH; {cout,sum} = a+b+cin exactly.
- Counter width: $clog2(WIDTH+1), minimum 1 bit.
- WIDTH=1: RUN lasts one cycle.
- Outputs driven from registers/state only; no combinational path from in_valid or out_ready to any output.
- Simultaneous events:
  - in_valid in DONE is ignored, even on the cycle out_ready=1; the request is accepted in IDLE next cycle if still asserted.
  - out_ready in IDLE/RUN is ignored.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> out_valid exactly 8 cycles after the accept edge; sum=0x96, cout=0; busy high for 9 cycles with out_ready=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; a=0, b=0, cin=1 -> sum=0x01, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stable all 5 cycles; out_ready=1 -> IDLE next cycle, in_ready=1.
- Busy protection: toggle in_valid with new operands (a=0x11, b=0x22) during RUN and DONE of 0x5A+0x3C -> result still 0x96; second op accepted only once back in IDLE, yields 0x33.
- Reset mid-RUN, after 3 bits: pulse rst_n low asynchronously -> immediately in_ready=1, out_valid=0, busy=0, sum=0, cout=0; the next op 0x01+0x01 yields 0x02.
- WIDTH=1 build, random sweep: all 8 {a,b,cin} combinations -> {cout,sum}=a+b+cin, latency 1 cycle; plus 1000 random WIDTH=8 ops vs reference model with random out_ready stalls.
